// File: rtl/char_sequencer.sv
// Debounces a step and a mode button, then walks a fixed ASCII message either
// on each step press or on a free-running scroll timer, feeding the 7-seg decoder.
module char_sequencer #(
  parameter int                   DEBOUNCE_CYCLES = 250000,
  parameter int                   SCROLL_CYCLES   = 12500000,
  parameter int                   MSG_LEN         = 8,
  parameter logic [8*MSG_LEN-1:0] MSG             = "GO-BOARD"
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [7:0] o_Char,
  output logic [3:0] o_Index,
  output logic       o_Auto
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCROLL_CYCLES - 1);
  localparam logic [3:0]      IDX_LAST = 4'(MSG_LEN - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  // Bit 0 is the step button, bit 1 is the mode button throughout.
  logic [1:0]            swMeta_q, swSync_q;
  logic [1:0]            swDb_q, swDb_d;
  logic [1:0]            swPress_q, swPress_d;
  logic [1:0][DB_W-1:0]  dbCnt_q, dbCnt_d;
  mode_e                 mode_q, mode_d;
  logic [SC_W-1:0]       scroll_q, scroll_d;
  logic [3:0]            index_q, index_d;
  logic [7:0]            char_q, char_d;
  logic                  expire, advance;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      swMeta_q  <= '0;
      swSync_q  <= '0;
      swDb_q    <= '0;
      swPress_q <= '0;
      dbCnt_q   <= '0;
      mode_q    <= MANUAL;
      scroll_q  <= '0;
      index_q   <= '0;
      char_q    <= 8'h20;
    end else begin
      swMeta_q  <= {i_Switch_2, i_Switch_1};
      swSync_q  <= swMeta_q;
      swDb_q    <= swDb_d;
      swPress_q <= swPress_d;
      dbCnt_q   <= dbCnt_d;
      mode_q    <= mode_d;
      scroll_q  <= scroll_d;
      index_q   <= index_d;
      char_q    <= char_d;
    end
  end

  // A level is accepted only after it has differed for DEBOUNCE_CYCLES straight
  // cycles; the press strobe fires on the edge where a 0->1 level is accepted.
  always_comb begin
    swDb_d    = swDb_q;
    swPress_d = '0;
    dbCnt_d   = '0;
    for (int s = 0; s < 2; s++) begin
      if (swSync_q[s] != swDb_q[s]) begin
        if (dbCnt_q[s] == DB_LAST) begin
          swDb_d[s]    = swSync_q[s];
          swPress_d[s] = swSync_q[s];
        end else begin
          dbCnt_d[s] = dbCnt_q[s] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (swPress_q[1]) begin
      mode_d = (mode_q == MANUAL) ? AUTO : MANUAL;
    end

    expire  = (mode_q == AUTO) && (scroll_q == SC_LAST);
    advance = swPress_q[0] || expire;

    index_d = index_q;
    if (advance) begin
      index_d = (index_q == IDX_LAST) ? 4'd0 : index_q + 4'd1;
    end

    // Any advance restarts the full period; entering AUTO starts from zero.
    scroll_d = scroll_q + SC_W'(1);
    if (mode_d == MANUAL || mode_q == MANUAL || advance) begin
      scroll_d = '0;
    end

    char_d = 8'h20;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (index_q == 4'(k)) begin
        char_d = MSG[8*(MSG_LEN-1-k) +: 8];
      end
    end
  end

  assign o_Char  = char_q;
  assign o_Index = index_q;
  assign o_Auto  = (mode_q == AUTO);

endmodule

// File: tb/tb_char_sequencer.sv
// Directed bench for char_sequencer with short debounce/scroll periods and a
// four-character message "GO-1".
module tb_char_sequencer;

  localparam int          DB  = 4;
  localparam int          SC  = 10;
  localparam int          LEN = 4;
  localparam logic [31:0] MSGV = "GO-1";

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic [7:0] charOut;
  logic [3:0] idxOut;
  logic       autoOut;

  int testsRun = 0;
  int testsFailed = 0;

  char_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .SCROLL_CYCLES  (SC),
    .MSG_LEN        (LEN),
    .MSG            (MSGV)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rstN),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .o_Char    (charOut),
    .o_Index   (idxOut),
    .o_Auto    (autoOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    rstN = 1'b0;
    sw1  = 1'b0;
    sw2  = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // Raise the mode button and return once AUTO is seen; found=0 on timeout.
  task automatic enterAuto(output bit found);
    int n;
    found = 1'b0;
    n = 0;
    sw2 = 1'b1;
    while (!found && n < 20) begin
      tick();
      n++;
      if (autoOut === 1'b1) found = 1'b1;
    end
    sw2 = 1'b0;
  endtask

  task automatic pressStep();
    sw1 = 1'b1;
    repeat (10) tick();
    sw1 = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    sw1 = 1'b0;
    sw2 = 1'b0;
    tick();
    tick();
    testsRun++;
    if (idxOut !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_index: got %0d expected 0", idxOut); end
    testsRun++;
    if (autoOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_auto: got %0b expected 0", autoOut); end
    testsRun++;
    if (charOut !== 8'h20) begin testsFailed++; $display("[TB] FAIL reset_char: got %h expected 20", charOut); end
    rstN = 1'b1;
    tick();
    testsRun++;
    if (charOut !== 8'h47) begin testsFailed++; $display("[TB] FAIL first_char: got %h expected 47", charOut); end
  endtask

  task automatic test_debounce();
    int changes;
    logic [3:0] prev;
    bit pending;
    sw1 = 1'b1;
    repeat (3) tick();
    sw1 = 1'b0;
    repeat (12) tick();
    testsRun++;
    if (idxOut !== 4'd0) begin testsFailed++; $display("[TB] FAIL glitch_ignored: got %0d expected 0", idxOut); end

    changes = 0;
    prev = idxOut;
    pending = 1'b0;
    sw1 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c == 20) sw1 = 1'b0;
      tick();
      if (pending) begin
        pending = 1'b0;
        testsRun++;
        if (charOut !== 8'h4F) begin testsFailed++; $display("[TB] FAIL char_after_index: got %h expected 4f", charOut); end
      end
      if (idxOut !== prev) begin
        changes++;
        prev = idxOut;
        pending = 1'b1;
        testsRun++;
        if (charOut !== 8'h47) begin testsFailed++; $display("[TB] FAIL char_lag: got %h expected 47", charOut); end
      end
    end
    testsRun++;
    if (changes != 1) begin testsFailed++; $display("[TB] FAIL hold_single_press: got %0d changes expected 1", changes); end
    testsRun++;
    if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL hold_index: got %0d expected 1", idxOut); end
  endtask

  task automatic test_manual_wrap();
    logic [7:0] expChar [4] = '{8'h4F, 8'h2D, 8'h31, 8'h47};
    logic [3:0] expIdx  [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    doReset();
    for (int i = 0; i < 4; i++) begin
      pressStep();
      testsRun++;
      if (idxOut !== expIdx[i]) begin testsFailed++; $display("[TB] FAIL manual_index[%0d]: got %0d expected %0d", i, idxOut, expIdx[i]); end
      testsRun++;
      if (charOut !== expChar[i]) begin testsFailed++; $display("[TB] FAIL manual_char[%0d]: got %h expected %h", i, charOut, expChar[i]); end
    end
  endtask

  task automatic test_auto_scroll();
    bit found;
    int n;
    doReset();
    enterAuto(found);
    testsRun++;
    if (!found) begin testsFailed++; $display("[TB] FAIL enter_auto: got %0b expected 1", autoOut); end
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k % 10 == 9 || k % 10 == 0) begin
        testsRun++;
        if (idxOut !== 4'((k / 10) % 4)) begin
          testsFailed++;
          $display("[TB] FAIL auto_index_k%0d: got %0d expected %0d", k, idxOut, (k / 10) % 4);
        end
      end
    end
    sw2 = 1'b1;
    n = 0;
    while (autoOut !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    sw2 = 1'b0;
    testsRun++;
    if (autoOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL leave_auto: got %0b expected 0", autoOut); end
    testsRun++;
    if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL freeze_index: got %0d expected 1", idxOut); end
    repeat (30) tick();
    testsRun++;
    if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL frozen_index: got %0d expected 1", idxOut); end
  endtask

  task automatic test_press_at_expiry();
    bit found;
    doReset();
    enterAuto(found);
    testsRun++;
    if (!found) begin testsFailed++; $display("[TB] FAIL enter_auto2: got %0b expected 1", autoOut); end
    for (int k = 1; k <= 51; k++) begin
      tick();
      if (k == 13) sw1 = 1'b1;
      if (k == 20) sw1 = 1'b0;
      if (k == 34) sw1 = 1'b1;
      if (k == 44) sw1 = 1'b0;
      if (k == 10 || k == 19 || k == 20 || k == 29 || k == 30 || k == 40 || k == 41 || k == 50 || k == 51) begin
        logic [3:0] exp;
        case (k)
          10, 19:     exp = 4'd1;
          20, 29:     exp = 4'd2;
          30:         exp = 4'd3;
          40:         exp = 4'd0;
          41, 50:     exp = 4'd1;
          default:    exp = 4'd2;
        endcase
        testsRun++;
        if (idxOut !== exp) begin testsFailed++; $display("[TB] FAIL expiry_index_k%0d: got %0d expected %0d", k, idxOut, exp); end
      end
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    sw1 = 1'b1;
    sw2 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 10) begin
        sw1 = 1'b0;
        sw2 = 1'b0;
        testsRun++;
        if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL both_index: got %0d expected 1", idxOut); end
        testsRun++;
        if (autoOut !== 1'b1) begin testsFailed++; $display("[TB] FAIL both_auto: got %0b expected 1", autoOut); end
      end
      if (c == 16) begin
        testsRun++;
        if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL both_hold: got %0d expected 1", idxOut); end
      end
      if (c == 17) begin
        testsRun++;
        if (idxOut !== 4'd2) begin testsFailed++; $display("[TB] FAIL both_period: got %0d expected 2", idxOut); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int changes;
    doReset();
    enterAuto(found);
    repeat (25) tick();
    testsRun++;
    if (idxOut !== 4'd2) begin testsFailed++; $display("[TB] FAIL pre_reset_index: got %0d expected 2", idxOut); end
    #2 rstN = 1'b0;
    #1;
    testsRun++;
    if (idxOut !== 4'd0 || autoOut !== 1'b0 || charOut !== 8'h20) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got idx=%0d auto=%0b char=%h expected 0 0 20", idxOut, autoOut, charOut);
    end
    tick();
    rstN = 1'b1;
    changes = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (idxOut !== 4'd0) changes++;
    end
    testsRun++;
    if (changes != 0 || autoOut !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle: got %0d nonzero-index cycles auto=%0b expected 0 0", changes, autoOut);
    end
    testsRun++;
    if (charOut !== 8'h47) begin testsFailed++; $display("[TB] FAIL post_reset_char: got %h expected 47", charOut); end
  endtask

  task automatic test_held_at_reset();
    rstN = 1'b0;
    sw1 = 1'b1;
    sw2 = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    repeat (12) tick();
    testsRun++;
    if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL held_press: got %0d expected 1", idxOut); end
    repeat (10) tick();
    sw1 = 1'b0;
    repeat (10) tick();
    testsRun++;
    if (idxOut !== 4'd1) begin testsFailed++; $display("[TB] FAIL held_once: got %0d expected 1", idxOut); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_manual_wrap();
    test_auto_scroll();
    test_press_at_expiry();
    test_simultaneous();
    test_reset_mid();
    test_held_at_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/char_sequencer.md
Name: char_sequencer

Overview:
- Upstream stage for the ASCII character-select seven-segment decoder.
- Debounces two board switches and steps through a fixed message string.
- Drives the decoder's 8-bit ASCII character-select input, either on each manual button press or automatically on a scroll timer.
- o_Char connects directly to the decoder's character-select port; the decoder needs no glue logic.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a switch level change (10 ms at 25 MHz).
- SCROLL_CYCLES, 12500000: cycles per auto-advance step (0.5 s at 25 MHz).
- MSG_LEN, 8: number of characters in the message. Legal range 2..16.
- MSG, "GO-BOARD": 8*MSG_LEN-bit packed ASCII. Character 0 is in the most-significant byte.

Ports:
- i_Clk, input, 1: system clock.
- i_Rst_L, input, 1: asynchronous active-low reset.
- i_Switch_1, input, 1: raw step button, active high. Asynchronous to i_Clk.
- i_Switch_2, input, 1: raw mode button, active high. Asynchronous to i_Clk.
- o_Char, output, 8: ASCII code of the current message character.
- o_Index, output, 4: current message index, 0..MSG_LEN-1.
- o_Auto, output, 1: 1 = AUTO mode, 0 = MANUAL mode.

Behaviour:
- Reset (i_Rst_L = 0, asynchronous): all flops clear.
  - o_Index = 0, o_Auto = 0, o_Char = 8'h20 (space).
  - Debounced levels = 0, debounce and scroll counters = 0.
- Synchronisers: each raw switch passes through a 2-flop synchroniser.
- Debounce, per switch, separate counter:
  - If the synchronised level differs from the debounced level, the counter increments. Otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is ignored.
- Press pulse: 1-cycle strobe on a debounced 0->1 transition. A release (1->0) generates nothing. Holding a button gives exactly one press.
- Mode FSM, states MANUAL and AUTO:
  - A Switch_2 press toggles the state.
  - On entry to AUTO, the scroll counter clears.
  - o_Auto is the registered state.
- Index advance:
  - MANUAL: a Switch_1 press increments the index.
  - AUTO: the scroll counter counts 0..SCROLL_CYCLES-1. On reaching SCROLL_CYCLES-1 the index increments and the counter clears.
  - AUTO with a Switch_1 press: the index increments and the scroll counter clears, restarting the full period.
  - Wrap: index MSG_LEN-1 increments to 0.
  - The scroll counter is held at 0 in MANUAL.
- Simultaneous events:
  - Switch_1 press and timer expiry in the same cycle: single increment, counter clears.
  - Switch_1 and Switch_2 presses in the same cycle: the mode toggles and the index increments once. If the new mode is AUTO, the counter clears.
- Latency:
  - Press pulse to o_Index update: 1 cycle.
  - o_Index to o_Char: 1 cycle. o_Char is registered as MSG byte [o_Index].
  - After reset release, o_Char becomes MSG[0] on the first clock edge.
- Reset mid-debounce or mid-scroll: all partial counts are discarded and no press is generated on release of reset.
  - A switch already held at reset release is debounced normally and yields one press once stable for DEBOUNCE_CYCLES.
- Widths:
  - Counters are sized with $clog2 of their parameter.
  - The index is 4 bits, upper bits 0 when MSG_LEN <= 8.
  - No other arithmetic.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10, MSG_LEN=4, MSG="GO-1"):
1. Reset, then release i_Rst_L -> o_Index=0, o_Auto=0, o_Char=8'h20 during reset, and o_Char=8'h47 ('G') one edge after release.
2. Hold Switch_1 high for 3 cycles, then low -> no index change. Hold high for 20 cycles -> o_Index 0->1 exactly once and o_Char=8'h4F ('O') one cycle after the index change.
3. Four clean Switch_1 presses from index 0 -> o_Char sequence 'O','-','1','G' (8'h4F, 8'h2D, 8'h31, 8'h47), with the index wrapping 3->0.
4. Switch_2 press -> o_Auto=1. Then with no input, the index advances every 10 cycles: 0->1->2->3->0. A second Switch_2 press -> o_Auto=0 and the index freezes.
5. In AUTO, Switch_1 press lands in the same cycle as timer expiry -> index advances by exactly 1 and the next auto advance occurs 10 cycles later.
6. In AUTO with index=2, assert i_Rst_L=0 mid-count -> o_Index=0, o_Auto=0, o_Char=8'h20 immediately without a clock edge. After release, no advance occurs over 50 cycles.
